alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Instruction-side controller that drives the CPU ALU's operand/select interface: accepts one 32-bit R-type or I-type arithmetic/logic/shift instruction via valid/ready, reads two source registers from the synchronous-read register file, presents A/B/ALU_Sel/Shamt to the ALU, and captures the result and Zero flag. It then writes the result back to the register file. It sits between instruction fetch and the ALU/register-file pair, replacing hard-wired control in the single-issue datapath.

## Interface
- No parameters. Data width is fixed at 32, register index width at 5, ALU select width at 4.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  32  fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2/shamt[24:20], funct7[31:25].
- rf_raddr1, rf_raddr2  out  5  register-file read addresses. Read data is valid the cycle after the address is presented.
- rf_rdata1, rf_rdata2  in  32  register-file read data.
- alu_a, alu_b  out  32  ALU operands.
- alu_sel  out  4  ALU operation select.
- alu_shamt  out  5  ALU shift amount.
- alu_out  in  32  ALU result (combinational from the ALU inputs).
- alu_zero  in  1  ALU zero flag.
- rf_we  out  1  register-file write enable (single-cycle pulse).
- rf_waddr  out  5  write address.
- rf_wdata  out  32  write data.
- done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  qualifies `done`: the retired instruction was unsupported.
- result  out  32  last retired result; holds until the next retire.
- zero_flag  out  1  last retired Zero flag; holds until the next retire.

## Operation
- States: IDLE, READ, EXEC, WB, ERR.
- IDLE: instr_ready=1. When instr_valid is high:
  - latch instr;
  - decode it;
  - drive rf_raddr1=rs1 and rf_raddr2=rs2;
  - go to READ if legal, else ERR.
- READ: wait one cycle for the register-file data. Go to EXEC.
- EXEC: drive alu_a, alu_b, alu_sel and alu_shamt from the latched decode and the read data. Register alu_out into result and alu_zero into zero_flag. Go to WB.
- WB: drive done=1, rf_we=(rd!=0), rf_waddr=rd, rf_wdata=result. Go to IDLE.
- ERR: drive done=1 and illegal=1, with rf_we=0. result and zero_flag are unchanged. Go to IDLE.
- R-type decode (opcode 0110011):
  - funct3 000 with funct7 0000000 → ADD (0000); with funct7 0100000 → SUB (0001).
  - funct3 111 → AND (0010); 110 → OR (0011); 100 → XOR (0100).
  - funct3 001 → SLL (0101); funct3 101 → SRL (0110) when funct7=0000000, SRA (0111) when funct7=0100000.
  - alu_b = rs2 data. For shifts, alu_shamt = rs2 data[4:0].
- I-type decode (opcode 0010011):
  - ADDI, ANDI, ORI, XORI use the same funct3 mapping as R-type, with alu_b = sign-extended instr[31:20].
  - SLLI, SRLI, SRAI take alu_shamt from instr[24:20], with funct7 checked as for R-type.
  - rf_raddr2 is don't-care.
- Illegal instruction: any other opcode, funct3 or funct7 combination.
- Outside EXEC: alu_a, alu_b, alu_sel and alu_shamt hold their last values.
- Zero flag: taken from alu_zero. It is not recomputed locally.

## Timing
- Reset values:
  - state=IDLE, instr_ready=1;
  - rf_raddr1=0, rf_raddr2=0;
  - alu_a=0, alu_b=0, alu_sel=0, alu_shamt=0;
  - rf_we=0, rf_waddr=0, rf_wdata=0;
  - done=0, illegal=0, result=0, zero_flag=0.
- Legal instruction: accepted at cycle 0, done and rf_we at cycle 3, next accept possible at cycle 4. This gives 4 cycles per instruction.
- Illegal instruction: done and illegal at cycle 1, next accept at cycle 2.
- instr_ready is low in READ, EXEC, WB and ERR. instr_valid is ignored in those states, and instr may change freely there.
- rst asserted in any state: the next state is IDLE and all outputs take their reset values. No write occurs, even if rst coincides with WB.
- rd=0: done still pulses and result updates, but rf_we=0.

## Structure
- Shared package alu_pkg holds:
  - ALU_Sel constants (ALU_ADD through ALU_SRA);
  - opcode constants OP_R=0110011 and OP_I=0010011;
  - funct3 and funct7 constants;
  - the state encoding.
- Sub-module alu_decode (combinational): takes instr; produces alu_sel, use_imm, shamt_from_imm, imm32, legal.

## Test plan
- Reset mid-EXEC with x1=5 loaded: the next cycle is IDLE, instr_ready=1, no rf_we is ever seen, and result=0.
- ADD x3,x1,x2 with x1=7, x2=9: at cycle 3, rf_we=1, rf_waddr=3, rf_wdata=16, zero_flag=0.
- SUB x4,x1,x1 with x1=0x1234: rf_wdata=0, zero_flag=1, alu_sel=0001 during EXEC.
- SRAI x5,x6,4 with x6=0x80000000: alu_shamt=4, alu_sel=0111, rf_wdata=0xF8000000. ADDI x7,x0,-1 gives 0xFFFFFFFF.
- opcode 1100011: done=1 and illegal=1 at cycle 1, rf_we stays 0, result keeps its previous value, accept again at cycle 2.
- ADD x0,x1,x2 followed back-to-back by OR x8,x1,x2 with instr_valid held high: first done with rf_we=0, second accepted 4 cycles after the first, rf_wdata=x1|x2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU select codes, opcode
// and function-field constants, and the controller state encoding.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [SEL_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [SEL_W-1:0] ALU_AND = 4'b0010;
    localparam logic [SEL_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [SEL_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [SEL_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [SEL_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [SEL_W-1:0] ALU_SRA = 4'b0111;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decoder for the supported R-type and I-type arithmetic,
// logic and shift instructions.
module alu_decode
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              use_imm,
    output logic              shamt_from_imm,
    output logic [DATA_W-1:0] imm32,
    output logic              legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm32  = {{20{instr[31]}}, instr[31:20]};
    // Register indices are taken directly from the latched word by the top.
    assign unused_fields = ^instr[19:7];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_sel        = ALU_ADD;
        use_imm        = 1'b0;
        shamt_from_imm = 1'b0;
        legal          = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE) begin
                            alu_sel = ALU_ADD;
                            legal   = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            alu_sel = ALU_SUB;
                            legal   = 1'b1;
                        end
                    end
                    F3_AND: begin alu_sel = ALU_AND; legal = (funct7 == F7_BASE); end
                    F3_OR:  begin alu_sel = ALU_OR;  legal = (funct7 == F7_BASE); end
                    F3_XOR: begin alu_sel = ALU_XOR; legal = (funct7 == F7_BASE); end
                    F3_SLL: begin alu_sel = ALU_SLL; legal = (funct7 == F7_BASE); end
                    F3_SRL: begin
                        if (funct7 == F7_BASE) begin
                            alu_sel = ALU_SRL;
                            legal   = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            alu_sel = ALU_SRA;
                            legal   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                use_imm = 1'b1;
                case (funct3)
                    F3_ADD: begin alu_sel = ALU_ADD; legal = 1'b1; end
                    F3_AND: begin alu_sel = ALU_AND; legal = 1'b1; end
                    F3_OR:  begin alu_sel = ALU_OR;  legal = 1'b1; end
                    F3_XOR: begin alu_sel = ALU_XOR; legal = 1'b1; end
                    F3_SLL: begin
                        alu_sel        = ALU_SLL;
                        shamt_from_imm = 1'b1;
                        legal          = (funct7 == F7_BASE);
                    end
                    F3_SRL: begin
                        shamt_from_imm = 1'b1;
                        if (funct7 == F7_BASE) begin
                            alu_sel = ALU_SRL;
                            legal   = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            alu_sel = ALU_SRA;
                            legal   = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: accepts one ALU instruction, reads operands from a
// synchronous-read register file, drives the ALU, and writes the result back.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_W-1:0]  rf_raddr1,
    output logic [REG_W-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic [REG_W-1:0]  alu_shamt,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag
);

    state_t              state_q,     state_d;
    logic [DATA_W-1:0]   instr_q,     instr_d;
    logic                ready_q,     ready_d;
    logic [REG_W-1:0]    raddr1_q,    raddr1_d;
    logic [REG_W-1:0]    raddr2_q,    raddr2_d;
    logic [DATA_W-1:0]   alu_a_q,     alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,     alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q,   alu_sel_d;
    logic [REG_W-1:0]    alu_shamt_q, alu_shamt_d;
    logic                rf_we_q,     rf_we_d;
    logic [REG_W-1:0]    rf_waddr_q,  rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q,  rf_wdata_d;
    logic                done_q,      done_d;
    logic                illegal_q,   illegal_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic                zero_q,      zero_d;

    logic [DATA_W-1:0]   dec_instr;
    logic [SEL_W-1:0]    dec_sel;
    logic                dec_use_imm;
    logic                dec_shamt_from_imm;
    logic [DATA_W-1:0]   dec_imm32;
    logic                dec_legal;

    // The decoder checks the incoming word at accept time and the latched word afterwards.
    assign dec_instr = (state_q == S_IDLE) ? instr : instr_q;

    alu_decode u_decode (
        .instr          (dec_instr),
        .alu_sel        (dec_sel),
        .use_imm        (dec_use_imm),
        .shamt_from_imm (dec_shamt_from_imm),
        .imm32          (dec_imm32),
        .legal          (dec_legal)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        ready_d     = ready_q;
        raddr1_d    = raddr1_q;
        raddr2_d    = raddr2_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        alu_shamt_d = alu_shamt_q;
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        done_d      = 1'b0;
        illegal_d   = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d  = instr;
                    raddr1_d = instr[19:15];
                    raddr2_d = instr[24:20];
                    ready_d  = 1'b0;
                    if (dec_legal) begin
                        state_d = S_READ;
                    end else begin
                        state_d   = S_ERR;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                    end
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                alu_a_d     = rf_rdata1;
                alu_b_d     = dec_use_imm ? dec_imm32 : rf_rdata2;
                alu_sel_d   = dec_sel;
                alu_shamt_d = dec_shamt_from_imm ? instr_q[24:20] : rf_rdata2[4:0];
                result_d    = alu_out;
                zero_d      = alu_zero;
                rf_we_d     = (instr_q[11:7] != '0);
                rf_waddr_d  = instr_q[11:7];
                rf_wdata_d  = alu_out;
                done_d      = 1'b1;
                state_d     = S_WB;
            end
            S_WB, S_ERR: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            instr_q     <= '0;
            ready_q     <= 1'b1;
            raddr1_q    <= '0;
            raddr2_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_shamt_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            ready_q     <= ready_d;
            raddr1_q    <= raddr1_d;
            raddr2_q    <= raddr2_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            alu_shamt_q <= alu_shamt_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
            illegal_q   <= illegal_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    // ALU operands must reach the ALU within EXEC so its result is captured on the same edge.
    assign alu_a       = alu_a_d;
    assign alu_b       = alu_b_d;
    assign alu_sel     = alu_sel_d;
    assign alu_shamt   = alu_shamt_d;

    assign instr_ready = ready_q;
    assign rf_raddr1   = raddr1_q;
    assign rf_raddr2   = raddr2_q;
    // A reset landing in WB must suppress the write that the register file would take on that edge.
    assign rf_we       = rf_we_q & ~rst;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign result      = result_q;
    assign zero_flag   = zero_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural register file and ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_out;
    logic        alu_zero;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done, illegal;
    logic [31:0] result;
    logic        zero_flag;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    int we_snap;

    logic [31:0] regs [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_shamt   (alu_shamt),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .done        (done),
        .illegal     (illegal),
        .result      (result),
        .zero_flag   (zero_flag)
    );

    // Synchronous-read register file; x0 always reads zero.
    always @(posedge clk) begin
        rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : regs[rf_raddr1];
        rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : regs[rf_raddr2];
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (rf_we && rf_waddr != 5'd0) regs[rf_waddr] <= rf_wdata;
    end

    always @(negedge clk) if (rf_we === 1'b1) we_count++;

    always_comb begin
        case (alu_sel)
            4'b0000: alu_out = alu_a + alu_b;
            4'b0001: alu_out = alu_a - alu_b;
            4'b0010: alu_out = alu_a & alu_b;
            4'b0011: alu_out = alu_a | alu_b;
            4'b0100: alu_out = alu_a ^ alu_b;
            4'b0101: alu_out = alu_a << alu_shamt;
            4'b0110: alu_out = alu_a >> alu_shamt;
            4'b0111: alu_out = $unsigned($signed(alu_a) >>> alu_shamt);
            default: alu_out = 32'd0;
        endcase
        alu_zero = (alu_out == 32'd0);
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    // Offers one instruction; returns in cycle 1 (the cycle after acceptance).
    task automatic issue(input logic [31:0] w);
        instr_valid = 1'b1; instr = w;
        step();
        instr_valid = 1'b0; instr = 32'hDEAD_BEEF;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        step(); step();
        check("rst_ready",   {31'd0, instr_ready}, 32'd1);
        check("rst_raddr1",  {27'd0, rf_raddr1},   32'd0);
        check("rst_raddr2",  {27'd0, rf_raddr2},   32'd0);
        check("rst_alu_a",   alu_a,                32'd0);
        check("rst_alu_sel", {28'd0, alu_sel},     32'd0);
        check("rst_rf_we",   {31'd0, rf_we},       32'd0);
        check("rst_done",    {31'd0, done},        32'd0);
        check("rst_result",  result,               32'd0);
        rst = 1'b0;
        step();

        // Reset while in EXEC: write is abandoned, outputs return to reset values.
        preload(5'd1, 32'd5);
        we_snap = we_count;
        issue(enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd9));
        step();
        check("rexec_alu_a", alu_a, 32'd5);
        rst = 1'b1;
        step();
        check("rexec_ready",  {31'd0, instr_ready}, 32'd1);
        check("rexec_result", result,               32'd0);
        check("rexec_done",   {31'd0, done},        32'd0);
        check("rexec_alu_a0", alu_a,                32'd0);
        rst = 1'b0;
        step(); step(); step();
        check("rexec_no_we", we_count, we_snap);
        check("rexec_x9",    regs[9],  32'd0);

        // ADD x3,x1,x2
        preload(5'd1, 32'd7);
        preload(5'd2, 32'd9);
        issue(enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3));
        check("add_ready_c1", {31'd0, instr_ready}, 32'd0);
        step();
        check("add_alu_a", alu_a, 32'd7);
        check("add_alu_b", alu_b, 32'd9);
        step();
        check("add_done",  {31'd0, done},     32'd1);
        check("add_we",    {31'd0, rf_we},    32'd1);
        check("add_waddr", {27'd0, rf_waddr}, 32'd3);
        check("add_wdata", rf_wdata,          32'd16);
        check("add_zero",  {31'd0, zero_flag}, 32'd0);
        check("add_ill",   {31'd0, illegal},  32'd0);
        step();
        check("add_ready_c4", {31'd0, instr_ready}, 32'd1);
        check("add_done_c4",  {31'd0, done},        32'd0);
        check("add_x3",       regs[3],              32'd16);

        // SUB x4,x1,x1
        preload(5'd1, 32'h0000_1234);
        issue(enc_r(7'b0100000, 5'd1, 5'd1, 3'b000, 5'd4));
        step();
        check("sub_sel", {28'd0, alu_sel}, 32'd1);
        step();
        check("sub_wdata", rf_wdata,           32'd0);
        check("sub_zero",  {31'd0, zero_flag}, 32'd1);
        step();

        // SRAI x5,x6,4
        preload(5'd6, 32'h8000_0000);
        issue(enc_i({7'b0100000, 5'd4}, 5'd6, 3'b101, 5'd5));
        step();
        check("srai_shamt", {27'd0, alu_shamt}, 32'd4);
        check("srai_sel",   {28'd0, alu_sel},   32'd7);
        step();
        check("srai_wdata", rf_wdata, 32'hF800_0000);
        step();

        // ADDI x7,x0,-1
        issue(enc_i(12'hFFF, 5'd0, 3'b000, 5'd7));
        step();
        check("addi_alu_b", alu_b, 32'hFFFF_FFFF);
        step();
        check("addi_wdata", rf_wdata,           32'hFFFF_FFFF);
        check("addi_zero",  {31'd0, zero_flag}, 32'd0);
        step();

        // Unsupported opcode 1100011
        we_snap = we_count;
        issue({25'd0, 7'b1100011});
        check("ill_done",   {31'd0, done},        32'd1);
        check("ill_flag",   {31'd0, illegal},     32'd1);
        check("ill_we",     {31'd0, rf_we},       32'd0);
        check("ill_result", result,               32'hFFFF_FFFF);
        check("ill_ready1", {31'd0, instr_ready}, 32'd0);
        step();
        check("ill_ready2", {31'd0, instr_ready}, 32'd1);
        check("ill_done2",  {31'd0, done},        32'd0);
        check("ill_no_we",  we_count,             we_snap);

        // AND with funct7=0100000 is not a supported encoding.
        issue(enc_r(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd10));
        check("ill_f7_flag", {31'd0, illegal}, 32'd1);
        step();

        // ADD x0 then OR x8 back-to-back with instr_valid held high.
        preload(5'd1, 32'h0000_000C);
        preload(5'd2, 32'h0000_000A);
        we_snap = we_count;
        instr_valid = 1'b1;
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0);
        step();
        instr = enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd8);
        check("b2b_ready_c1", {31'd0, instr_ready}, 32'd0);
        step(); step();
        check("b2b_x0_done",   {31'd0, done},  32'd1);
        check("b2b_x0_we",     {31'd0, rf_we}, 32'd0);
        check("b2b_x0_result", result,         32'h0000_0016);
        step();
        check("b2b_ready_c4", {31'd0, instr_ready}, 32'd1);
        step();
        instr_valid = 1'b0;
        check("b2b_ready_c5", {31'd0, instr_ready}, 32'd0);
        check("b2b_x0_no_we", we_count,             we_snap);
        step(); step();
        check("b2b_or_done",  {31'd0, done},     32'd1);
        check("b2b_or_we",    {31'd0, rf_we},    32'd1);
        check("b2b_or_waddr", {27'd0, rf_waddr}, 32'd8);
        check("b2b_or_wdata", rf_wdata,          32'h0000_000E);
        step();
        check("b2b_x8", regs[8], 32'h0000_000E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
